// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and register constants for the hazard sequencer
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MUL_DONE = 2'd2
    } state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline hazard inputs and enable/flush/multiplier controls
interface hazard_stall_ctrl_if;
    import hazard_pkg::*;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_rt;
    logic [4:0] IFID_rs;
    logic [4:0] IFID_rt;
    logic       ID_uses_rt;
    logic       EX_branch_taken;
    logic       EX_is_mul;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_bubble;
    logic       mul_start;
    logic       mul_done;
    modport master (
        output IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, ID_uses_rt, EX_branch_taken, EX_is_mul,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               mul_start, mul_done
    );
    modport slave (
        input  IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, ID_uses_rt, EX_branch_taken, EX_is_mul,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               mul_start, mul_done
    );
endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the ID instruction
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rt,
    output logic       hit
);
    assign hit = mem_read && ex_rt != REG_ZERO && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and multi-cycle multiply freeze sequencer.
// HAZARD_PERF_EN adds saturating stall_cycles/flush_count counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    hazard_stall_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lu_hit;

    load_use_detect u_lud (
        .mem_read (hz.IDEX_MemRead),
        .ex_rt    (hz.IDEX_rt),
        .id_rs    (hz.IFID_rs),
        .id_rt    (hz.IFID_rt),
        .uses_rt  (hz.ID_uses_rt),
        .hit      (lu_hit)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_write   = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.mul_start    = 1'b0;
        hz.mul_done     = 1'b0;
        if (!reset) begin
            if (state_q == MUL_WAIT) begin
                {hz.pc_write, hz.ifid_write, hz.idex_write} = 3'b000;
                hz.exmem_bubble = 1'b1;
                state_d         = (cnt_q == CNT_W'(1)) ? MUL_DONE : MUL_WAIT;
                cnt_d           = cnt_q - 1'b1;
            end else if (state_q == RUN && hz.EX_is_mul) begin
                {hz.pc_write, hz.ifid_write, hz.idex_write} = 3'b000;
                hz.exmem_bubble = 1'b1;
                hz.mul_start    = 1'b1;
                cnt_d           = CNT_W'(MUL_LATENCY - 1);
                state_d         = MUL_WAIT;
            end else begin
                // MUL_DONE ignores EX_is_mul: the finishing multiply is still in EX
                hz.mul_done = (state_q == MUL_DONE);
                state_d     = RUN;
                if (hz.EX_branch_taken) begin
                    hz.ifid_flush  = 1'b1;
                    hz.idex_bubble = 1'b1;
                end else if (lu_hit) begin
                    hz.pc_write    = 1'b0;
                    hz.ifid_write  = 1'b0;
                    hz.idex_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = (!hz.pc_write && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        flush_d = (hz.ifid_flush && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a per-cycle behavioural model and literal checks
module tb_hazard_stall_ctrl;
    localparam int L = 4;
    localparam logic [7:0] D  = 8'b1101_0000;
    localparam logic [7:0] S  = 8'b0001_1000;
    localparam logic [7:0] B  = 8'b1111_1000;
    localparam logic [7:0] F1 = 8'b0000_0110;
    localparam logic [7:0] F  = 8'b0000_0100;
    localparam logic [7:0] M  = 8'b1101_0001;
    localparam logic [7:0] MB = 8'b1111_1001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hazard_stall_ctrl_if hz ();
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_count;
    hazard_stall_ctrl #(.MUL_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .hz(hz),
        .stall_cycles(stall_cycles), .flush_count(flush_count));
`else
    hazard_stall_ctrl #(.MUL_LATENCY(L), .CNT_W(4)) dut (.clk(clk), .reset(reset), .hz(hz));
`endif

    always #5 clk = ~clk;

    wire [7:0] dut_v = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
                        hz.idex_bubble, hz.exmem_bubble, hz.mul_start, hz.mul_done};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic uses, input logic br, input logic mul);
        hz.IDEX_MemRead = mr;
        hz.IDEX_rt = rt;
        hz.IFID_rs = rs;
        hz.IFID_rt = irt;
        hz.ID_uses_rt = uses;
        hz.EX_branch_taken = br;
        hz.EX_is_mul = mul;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] irt, input logic uses, input logic br, input logic mul);
        @(posedge clk);
        #1 set(mr, rt, rs, irt, uses, br, mul);
    endtask

    task automatic expect_v(input string name, input logic [7:0] exp);
        @(negedge clk);
        #1 chk(name, {24'd0, dut_v}, {24'd0, exp});
    endtask

    // Model: freeze_left counts frozen cycles still owed after the start cycle
    int   freeze_left = 0;
    bit   done_pend = 0;
    int   m_stall = 0, m_flush = 0;
    logic [7:0] mexp;
    bit   lu, started;

    always @(negedge clk) begin
        if (reset) begin
            mexp = D;
            freeze_left = 0;
            done_pend = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (freeze_left > 0) begin
            mexp = F;
            freeze_left--;
            if (freeze_left == 0) done_pend = 1;
        end else begin
            lu = hz.IDEX_MemRead && hz.IDEX_rt != 0 &&
                 (hz.IDEX_rt == hz.IFID_rs || (hz.ID_uses_rt && hz.IDEX_rt == hz.IFID_rt));
            mexp = D;
            started = 0;
            if (done_pend) mexp[0] = 1'b1;
            else if (hz.EX_is_mul) begin
                mexp = F1;
                freeze_left = L - 1;
                started = 1;
            end
            if (!started && hz.EX_branch_taken) mexp = mexp | 8'b0010_1000;
            else if (!started && lu) mexp = (mexp & 8'b0011_1111) | 8'b0000_1000;
            done_pend = 0;
        end
        chk("model_outputs", {24'd0, dut_v}, {24'd0, mexp});
`ifdef HAZARD_PERF_EN
        chk("model_stall_cycles", {16'd0, stall_cycles}, m_stall);
        chk("model_flush_count", {16'd0, flush_count}, m_flush);
`endif
        if (!reset && !mexp[7] && m_stall < 65535) m_stall++;
        if (!reset && mexp[5] && m_flush < 65535) m_flush++;
    end

    initial begin
        set(1, 8, 8, 0, 0, 0, 0);
        expect_v("reset_defaults", D);
        @(posedge clk);
        #1 reset = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        expect_v("run_idle", D);

        drive(1, 8, 8, 0, 0, 0, 0); expect_v("lu_rs_hit", S);
        drive(0, 8, 8, 0, 0, 0, 0); expect_v("lu_after", D);
        drive(1, 0, 0, 0, 0, 0, 0); expect_v("lu_reg0", D);
        drive(1, 9, 1, 9, 0, 0, 0); expect_v("lu_rt_unused", D);
        drive(1, 9, 1, 9, 1, 0, 0); expect_v("lu_rt_used", S);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("lu_rt_after", D);
        drive(1, 8, 8, 0, 0, 1, 0); expect_v("branch_over_lu", B);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("branch_after", D);

        drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul_start", F1);
        for (int i = 0; i < L - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul_freeze", F);
        end
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul_done", M);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("mul_release", D);

        drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul2_start", F1);
        for (int i = 0; i < L - 1; i++) begin
            drive(1, 8, 8, 0, 0, 1, 1); expect_v("mul2_ignore_hazards", F);
        end
        drive(0, 0, 0, 0, 0, 1, 1); expect_v("mul2_done_branch", MB);
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul_back_to_back", F1);
        for (int i = 0; i < L - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); expect_v("mul3_freeze", F);
        end
        drive(1, 8, 8, 0, 0, 0, 1); expect_v("mul3_done_lu", 8'b0001_1001);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("mul3_release", D);

        drive(0, 0, 0, 0, 0, 0, 1); expect_v("rst_mul_start", F1);
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("rst_mul_wait1", F);
        drive(0, 0, 0, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1 chk("async_rst_pc_write", {31'd0, hz.pc_write}, 32'd1);
        chk("async_rst_exmem_bubble", {31'd0, hz.exmem_bubble}, 32'd0);
        chk("async_rst_outputs", {24'd0, dut_v}, {24'd0, D});
        @(posedge clk);
        #1 reset = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        expect_v("after_rst_run", D);
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("after_rst_mul_start", F1);
        for (int i = 0; i < L - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); expect_v("after_rst_freeze", F);
        end
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("after_rst_done", M);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("after_rst_release", D);

`ifdef HAZARD_PERF_EN
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8, 8, 0, 0, 0, 0); expect_v("perf_lu", S);
            drive(0, 0, 0, 0, 0, 0, 0); expect_v("perf_lu_gap", D);
        end
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("perf_mul_start", F1);
        for (int i = 0; i < L - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); expect_v("perf_mul_freeze", F);
        end
        drive(0, 0, 0, 0, 0, 0, 1); expect_v("perf_mul_done", M);
        drive(0, 0, 0, 0, 0, 1, 0); expect_v("perf_branch1", B);
        drive(0, 0, 0, 0, 0, 1, 0); expect_v("perf_branch2", B);
        drive(0, 0, 0, 0, 0, 0, 0); expect_v("perf_idle", D);
        chk("perf_stall_cycles", {16'd0, stall_cycles}, 32'd7);
        chk("perf_flush_count", {16'd0, flush_count}, 32'd2);
`endif
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core; sits beside the forwarding unit and controls the pipeline-register enables, flushes and bubbles.
- Handles load-use stalls that forwarding cannot cover, taken-branch flushes, and a multi-cycle multiply in EX. For the multiply it freezes the pipeline for a fixed latency, then releases it.

Parameters:
- MUL_LATENCY, 4, cycles the multiplier needs from mul_start to valid result; legal range 2..15.
- CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_rt  input  5  destination register of the load in EX.
- IFID_rs  input  5  rs of the instruction in ID.
- IFID_rt  input  5  rt of the instruction in ID.
- ID_uses_rt  input  1  ID instruction reads rt (R-type, store, beq).
- EX_branch_taken  input  1  branch in EX resolved taken.
- EX_is_mul  input  1  instruction in EX is a multiply.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  zero IF/ID on the next edge.
- idex_write  output  1  ID/EX register enable.
- idex_bubble  output  1  zero the ID/EX control fields on the next edge.
- exmem_bubble  output  1  zero the EX/MEM control fields on the next edge.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_done  output  1  multiply result valid; EX/MEM captures it on this cycle.

Behaviour:
- FSM states: RUN, MUL_WAIT, MUL_DONE. Reset state is RUN; the counter resets to 0.
- While reset is high, all outputs are forced to their defaults: pc_write=1, ifid_write=1, idex_write=1; ifid_flush, idex_bubble, exmem_bubble, mul_start and mul_done all 0.
- Outputs are combinational from state and inputs. They take effect at the next rising edge.
- RUN, priority high to low:
  1. EX_is_mul=1: mul_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1. Load cnt=MUL_LATENCY-1. Next state MUL_WAIT.
  2. EX_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1. A concurrent load-use condition is ignored, because the ID instruction is being flushed.
  3. Load-use, defined as IDEX_MemRead && IDEX_rt!=0 && (IDEX_rt==IFID_rs || (ID_uses_rt && IDEX_rt==IFID_rt)): pc_write=0, ifid_write=0, idex_bubble=1. This lasts exactly one cycle; the following cycle the load has moved to MEM, and the forwarding unit supplies the value.
  4. Otherwise, all outputs stay at their defaults.
- MUL_WAIT:
  - Same freeze as RUN rule 1, but mul_start=0.
  - Hazard, branch and EX_is_mul inputs are ignored.
  - If cnt==1, the next state is MUL_DONE; otherwise cnt decrements.
- MUL_DONE:
  - mul_done=1, and all enables are released (defaults).
  - EX_is_mul is ignored, because it is the same multiply still in EX.
  - The branch and load-use rules of RUN apply.
  - Next state is RUN.
- Freeze timing: the pipeline is frozen for exactly MUL_LATENCY cycles, from the first RUN cycle with EX_is_mul through the last MUL_WAIT cycle.
- Back-to-back multiplies: a second multiply entering EX is seen in RUN and starts a new sequence.
- Reset asserted mid-sequence: the FSM returns to RUN immediately, mul_start and mul_done drop, and no release pulse is generated.
- All register indices are compared as 5-bit values. Register $0 never triggers a load-use stall.

Optional Feature:
- Macro name: HAZARD_PERF_EN.
- When defined, two extra output ports are present:
  - stall_cycles [15:0]: increments on every cycle with pc_write=0.
  - flush_count [15:0]: increments on every cycle with ifid_flush=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (hazard_pkg): FSM state encoding (RUN=2'd0, MUL_WAIT=2'd1, MUL_DONE=2'd2) and REG_ZERO=5'd0.
- The multiplier interface uses the same package.
- One natural sub-module, load_use_detect: a combinational comparator producing the load-use condition, kept separate so the verification bench can check it standalone.

Test Plan:
- Load-use hit: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8. Expect pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle, then defaults.
- Load-use filters:
  - IDEX_rt=0 with IFID_rs=0 → no stall.
  - IDEX_rt=9, IFID_rt=9, ID_uses_rt=0 → no stall.
  - Same case with ID_uses_rt=1 → stall for 1 cycle.
- Branch over load-use: EX_branch_taken=1 together with a load-use hit. Expect ifid_flush=1, idex_bubble=1, pc_write=1, with no stall.
- Multiply with MUL_LATENCY=4: EX_is_mul held high.
  - Expect mul_start high for 1 cycle.
  - Expect pc_write, ifid_write and idex_write low and exmem_bubble high for 4 consecutive cycles.
  - Then mul_done=1 for 1 cycle, followed by RUN with no second mul_start.
- Reset mid-multiply: assert reset during the 2nd MUL_WAIT cycle. Expect pc_write=1 and exmem_bubble=0 immediately (asynchronous), then RUN after release.
- HAZARD_PERF_EN defined: run 3 load-use stalls, 1 multiply (L=4) and 2 branches. Expect stall_cycles=7 and flush_count=2.
